// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - memory-side bus responder with wait states, address checks and internal RAM
// Optional byte-lane writes via MEM_BYTE_STROBE_EN (adds wstrb port).
module mem_bus_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
`ifdef MEM_BYTE_STROBE_EN
  input  logic [3:0]  wstrb,
`endif
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]    cnt;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          req_rd;
  logic          req_wr;
  logic          err_q;
  logic          below_base;
  logic          above_top;
  logic          strb_zero;
  logic          reject;
  logic [AW-1:0] idx;
  logic [31:0]   wmask;

  logic [31:0] mem [DEPTH_WORDS];

`ifdef MEM_BYTE_STROBE_EN
  logic [3:0] req_strb;

  assign strb_zero = req_wr & (req_strb == 4'b0000);
  assign wmask     = {{8{req_strb[3]}}, {8{req_strb[2]}}, {8{req_strb[1]}}, {8{req_strb[0]}}};
`else
  assign strb_zero = 1'b0;
  assign wmask     = 32'hFFFF_FFFF;
`endif

  // 33-bit compares so an address near 32'hFFFF_FFFC cannot wrap back into range
  assign below_base = 1'((33'(req_addr) - 33'(BASE_ADDR)) >> 32);
  assign above_top  = {1'b0, req_addr} >= LIMIT;
  assign idx        = AW'((req_addr - BASE_ADDR) >> 2);
  assign reject     = (req_rd & req_wr) | (req_addr[1:0] != 2'b00) | below_base | above_top | strb_zero;

  assign ready = (state == S_RESP);
  assign err   = ready & err_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (rd | wr) state_next = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
      end
      S_WAIT: begin
        if (cnt <= 4'd1) state_next = S_ACCESS;
      end
      S_ACCESS: state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 4'd0;
      rdata     <= 32'd0;
      err_q     <= 1'b0;
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
      req_rd    <= 1'b0;
      req_wr    <= 1'b0;
`ifdef MEM_BYTE_STROBE_EN
      req_strb  <= 4'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (rd | wr) begin
            req_addr  <= addr;
            req_wdata <= wdata;
            req_rd    <= rd;
            req_wr    <= wr;
`ifdef MEM_BYTE_STROBE_EN
            req_strb  <= wstrb;
`endif
            cnt       <= WAIT_INIT;
            err_q     <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        S_ACCESS: begin
          err_q <= reject;
          if (!reject && req_rd) rdata <= mem[idx];
        end
        default: ;
      endcase
    end
  end

  // Reset gating keeps an aborted write from landing in the RAM
  always_ff @(posedge clk) begin
    if (!reset && state == S_ACCESS && !reject && req_wr)
      mem[idx] <= (mem[idx] & ~wmask) | (req_wdata & wmask);
  end

endmodule
